// File: rtl/mandel_pkg.sv
// Shared types for the Mandelbrot engine and its pixel dispatcher.
// Coordinates are signed fixed point with FRAC fractional bits.
package mandel_pkg;

  localparam int FRAC = 16;
  localparam int DW   = 8;
  localparam int XW   = 10;
  localparam int YW   = 9;

  typedef logic signed [31:0] fixed_t;

  typedef struct packed {
    logic [DW-1:0] depth;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
  } pixel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } disp_state_t;

endpackage

// File: rtl/pixel_out_reg.sv
// One-entry valid/ready output register for the pixel stream.
// A load may coincide with the downstream accept of the old entry.
module pixel_out_reg
  import mandel_pkg::*;
(
  input  logic   sysclk,
  input  logic   reset,
  input  logic   load,
  input  pixel_t din,
  input  logic   ready,
  output logic   valid,
  output pixel_t dout,
  output logic   free
);

  assign free = ~valid | ready;

  // Slot register: reload wins over drain so a tied-high ready has no bubble.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Raster-order frame scanner feeding one depth engine per pixel.
// Coordinates advance by add/sub only; results leave on a valid/ready stream.
module pixel_dispatcher
  import mandel_pkg::*;
#(
  parameter int FRAC   = mandel_pkg::FRAC,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [31:0] re_min,
  input  logic [31:0] im_max,
  input  logic [31:0] step,
  output logic        calc_start,
  output logic [9:0]  calc_x,
  output logic [8:0]  calc_y,
  output logic [31:0] calc_re_c,
  output logic [31:0] calc_im_c,
  input  logic        calc_done,
  input  logic [7:0]  calc_depth,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [7:0]  px_data,
  output logic [9:0]  px_x,
  output logic [8:0]  px_y,
  output logic        px_sof,
  output logic        px_eol,
  output logic        frame_busy,
  output logic        frame_done
);

  if (WIDTH < 1 || WIDTH > 1024 || HEIGHT < 1 || HEIGHT > 512
      || FRAC < 0 || FRAC > 31) begin : g_bad_cfg
    $error("pixel_dispatcher: parameter out of range");
  end

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  disp_state_t   state;
  disp_state_t   nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  fixed_t        cur_re;
  fixed_t        cur_im;
  fixed_t        re_min_l;
  fixed_t        step_l;
  logic          latch;
  logic          adv;
  logic          load;
  logic          fd_set;
  logic          slot_free;
  logic          last;
  pixel_t        slot_in;
  pixel_t        slot_q;

  assign last = (x == X_LAST) && (y == Y_LAST);

  assign slot_in = '{
    depth: calc_depth,
    x:     x,
    y:     y,
    sof:   (x == '0) && (y == '0),
    eol:   (x == X_LAST)
  };

  // State register plus the registered end-of-frame pulse.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt;
      frame_done <= fd_set;
    end
  end

  // Next state; done is only looked at in WAIT, a cycle past the start pulse.
  always_comb begin
    nxt        = state;
    calc_start = 1'b0;
    latch      = 1'b0;
    load       = 1'b0;
    adv        = 1'b0;
    fd_set     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (frame_start) begin
          latch = 1'b1;
          nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        calc_start = 1'b1;
        nxt        = S_WAIT;
      end
      S_WAIT: begin
        if (calc_done) begin
          if (slot_free) begin
            load = 1'b1;
            adv  = ~last;
            nxt  = last ? S_DRAIN : S_ISSUE;
          end else begin
            nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (slot_free) begin
          load = 1'b1;
          adv  = ~last;
          nxt  = last ? S_DRAIN : S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (px_valid && px_ready) begin
          fd_set = 1'b1;
          nxt    = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Viewport latch and incremental raster walk; advance on the slot-load edge.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      cur_re   <= '0;
      cur_im   <= '0;
      re_min_l <= '0;
      step_l   <= '0;
    end else if (latch) begin
      x        <= '0;
      y        <= '0;
      cur_re   <= re_min;
      cur_im   <= im_max;
      re_min_l <= re_min;
      step_l   <= step;
    end else if (adv) begin
      if (x != X_LAST) begin
        x      <= x + 1'b1;
        cur_re <= cur_re + step_l;
      end else begin
        x      <= '0;
        y      <= y + 1'b1;
        cur_re <= re_min_l;
        cur_im <= cur_im - step_l;
      end
    end
  end

  pixel_out_reg u_out (
    .sysclk (sysclk),
    .reset  (reset),
    .load   (load),
    .din    (slot_in),
    .ready  (px_ready),
    .valid  (px_valid),
    .dout   (slot_q),
    .free   (slot_free)
  );

  assign calc_x     = x;
  assign calc_y     = y;
  assign calc_re_c  = cur_re;
  assign calc_im_c  = cur_im;
  assign px_data    = slot_q.depth;
  assign px_x       = slot_q.x;
  assign px_y       = slot_q.y;
  assign px_sof     = slot_q.sof;
  assign px_eol     = slot_q.eol;
  assign frame_busy = (state != S_IDLE);

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench: 4x2 dispatcher plus a 1x1 build, each with an engine model.
// Engine returns depth 3+x+y after five cycles of done low.
module tb_pixel_dispatcher;
  import mandel_pkg::*;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        fs_a   = 1'b0;
  logic        fs_b   = 1'b0;
  logic [31:0] re_min = '0;
  logic [31:0] im_max = '0;
  logic [31:0] step   = '0;
  logic        rdy    = 1'b0;

  logic        start_a, done_a, v_a, sof_a, eol_a, busy_a, fd_a;
  logic [9:0]  cx_a, px_x_a;
  logic [8:0]  cy_a, px_y_a;
  logic [31:0] re_a, im_a;
  logic [7:0]  dep_a, d_a;

  logic        start_b, done_b, v_b, sof_b, eol_b, busy_b, fd_b;
  logic [9:0]  cx_b, px_x_b;
  logic [8:0]  cy_b, px_y_b;
  logic [31:0] re_b, im_b;
  logic [7:0]  dep_b, d_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 sysclk = ~sysclk;

  pixel_dispatcher #(.WIDTH(4), .HEIGHT(2)) u_dut (
    .sysclk(sysclk), .reset(reset), .frame_start(fs_a),
    .re_min(re_min), .im_max(im_max), .step(step),
    .calc_start(start_a), .calc_x(cx_a), .calc_y(cy_a),
    .calc_re_c(re_a), .calc_im_c(im_a),
    .calc_done(done_a), .calc_depth(dep_a),
    .px_valid(v_a), .px_ready(rdy), .px_data(d_a),
    .px_x(px_x_a), .px_y(px_y_a), .px_sof(sof_a), .px_eol(eol_a),
    .frame_busy(busy_a), .frame_done(fd_a)
  );

  pixel_dispatcher #(.WIDTH(1), .HEIGHT(1)) u_one (
    .sysclk(sysclk), .reset(reset), .frame_start(fs_b),
    .re_min(re_min), .im_max(im_max), .step(step),
    .calc_start(start_b), .calc_x(cx_b), .calc_y(cy_b),
    .calc_re_c(re_b), .calc_im_c(im_b),
    .calc_done(done_b), .calc_depth(dep_b),
    .px_valid(v_b), .px_ready(rdy), .px_data(d_b),
    .px_x(px_x_b), .px_y(px_y_b), .px_sof(sof_b), .px_eol(eol_b),
    .frame_busy(busy_b), .frame_done(fd_b)
  );

  // Engine models: done drops on start, rises after five low cycles.
  int cnt_a, cnt_b;
  always @(posedge sysclk or posedge reset) begin
    if (reset) begin
      done_a <= 1'b0; dep_a <= '0; cnt_a <= 0;
    end else if (start_a) begin
      done_a <= 1'b0; cnt_a <= 5;
    end else if (cnt_a == 1) begin
      done_a <= 1'b1; dep_a <= 8'(3 + cx_a + cy_a); cnt_a <= 0;
    end else if (cnt_a > 1) begin
      cnt_a <= cnt_a - 1;
    end
  end

  always @(posedge sysclk or posedge reset) begin
    if (reset) begin
      done_b <= 1'b0; dep_b <= '0; cnt_b <= 0;
    end else if (start_b) begin
      done_b <= 1'b0; cnt_b <= 5;
    end else if (cnt_b == 1) begin
      done_b <= 1'b1; dep_b <= 8'(3 + cx_b + cy_b); cnt_b <= 0;
    end else if (cnt_b > 1) begin
      cnt_b <= cnt_b - 1;
    end
  end

  // Monitors: accepted pixels, frame_done pulses, start coords and spacing.
  pixel_t      q_a[$];
  pixel_t      q_b[$];
  int          fdc_a = 0;
  int          fdc_b = 0;
  int          nstart = 0;
  int          since = 0;
  bit          have_prev = 0;
  int          gap_min = 1000;
  logic [31:0] re_log [8];
  logic [31:0] im_log [8];

  always @(negedge sysclk) begin
    if (reset) begin
      have_prev <= 1'b0;
      since     <= 0;
    end else begin
      if (v_a && rdy) q_a.push_back({d_a, px_x_a, px_y_a, sof_a, eol_a});
      if (v_b && rdy) q_b.push_back({d_b, px_x_b, px_y_b, sof_b, eol_b});
      if (fd_a) fdc_a <= fdc_a + 1;
      if (fd_b) fdc_b <= fdc_b + 1;
      if (start_a) begin
        re_log[int'(cy_a) * 4 + int'(cx_a)] <= re_a;
        im_log[int'(cy_a) * 4 + int'(cx_a)] <= im_a;
        if (have_prev && since < gap_min) gap_min <= since;
        have_prev <= 1'b1;
        nstart    <= nstart + 1;
        since     <= 1;
      end else begin
        since <= since + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic start_a_frame(input logic [31:0] r, input logic [31:0] i,
                               input logic [31:0] s);
    tick(1);
    fs_a = 1'b1; re_min = r; im_max = i; step = s;
    tick(1);
    fs_a = 1'b0;
  endtask

  task automatic wait_fd_a(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (fd_a) break;
      tick(1);
    end
    if (k == budget) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_frame(input string tag);
    pixel_t e;
    check({tag, "_count"}, q_a.size(), 8);
    for (int i = 0; i < 8 && i < q_a.size(); i++) begin
      e.x     = 10'(i % 4);
      e.y     = 9'(i / 4);
      e.depth = 8'(3 + i % 4 + i / 4);
      e.sof   = (i == 0);
      e.eol   = (i % 4 == 3);
      check($sformatf("%s_px%0d", tag, i), q_a[i], e);
    end
  endtask

  int          fd0;
  int          ns0;
  bit          stable;
  logic [28:0] snap;

  initial begin
    tick(3);
    @(negedge sysclk);
    check("rst_px_valid", v_a, 0);
    check("rst_calc_start", start_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_re_c", re_a, 0);
    check("rst_px_data", {d_a, px_x_a, px_y_a}, 0);
    check("rst_one_valid", v_b, 0);
    tick(1);
    reset = 1'b0;

    // Full frame with ready tied high and a rejected mid-frame restart.
    rdy = 1'b1;
    fd0 = fdc_a;
    start_a_frame(32'hFFFE0000, 32'h00010000, 32'h00008000);
    check("busy_after_start", busy_a, 1);
    tick(10);
    fs_a = 1'b1; re_min = 32'h12345678; im_max = 32'h7; step = 32'h1;
    tick(1);
    fs_a = 1'b0;
    wait_fd_a("f1", 300);
    tick(3);
    check_frame("f1");
    check("re_1_0", re_log[1], 32'hFFFE8000);
    check("im_1_0", im_log[1], 32'h00010000);
    check("re_0_1", re_log[4], 32'hFFFE0000);
    check("im_0_1", im_log[4], 32'h00008000);
    check("re_3_1", re_log[7], 32'hFFFF8000);
    check("f1_done_pulses", fdc_a - fd0, 1);
    check("f1_busy_end", busy_a, 0);

    // Backpressure: first pixel parks, second result waits in HOLD.
    q_a.delete();
    rdy = 1'b0;
    start_a_frame(32'hFFFE0000, 32'h00010000, 32'h00008000);
    for (int k = 0; k < 50 && !v_a; k++) tick(1);
    check("bp_first_valid", v_a, 1);
    snap   = {d_a, px_x_a, px_y_a, sof_a, eol_a};
    ns0    = nstart;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if ({d_a, px_x_a, px_y_a, sof_a, eol_a} !== snap) stable = 1'b0;
    end
    check("bp_first_pixel", snap, {8'd3, 10'd0, 9'd0, 1'b1, 1'b0});
    check("bp_stable", stable, 1);
    check("bp_starts", nstart - ns0, 1);
    check("bp_hold_re", re_a, 32'hFFFE8000);
    check("bp_no_start", start_a, 0);
    fd0 = fdc_a;
    rdy = 1'b1;
    wait_fd_a("bp", 300);
    tick(3);
    check_frame("bp");
    check("bp_done_pulses", fdc_a - fd0, 1);

    // Reset while pixel (2,1) is in WAIT, then a clean frame.
    q_a.delete();
    start_a_frame(32'hFFFE0000, 32'h00010000, 32'h00008000);
    for (int k = 0; k < 200 && !(start_a && cx_a == 2 && cy_a == 1); k++)
      tick(1);
    check("rst_mid_reach", {start_a, cx_a, cy_a}, {1'b1, 10'd2, 9'd1});
    tick(1);
    fd0   = fdc_a;
    reset = 1'b1;
    @(negedge sysclk);
    check("rst_mid_outs",
          {v_a, d_a, px_x_a, px_y_a, sof_a, eol_a, start_a, cx_a, cy_a,
           busy_a, fd_a}, 0);
    check("rst_mid_coords", {re_a, im_a}, 0);
    tick(1);
    reset = 1'b0;
    tick(5);
    check("rst_mid_no_done", fdc_a - fd0, 0);
    q_a.delete();
    start_a_frame(32'hFFFE0000, 32'h00010000, 32'h00008000);
    wait_fd_a("f3", 300);
    tick(3);
    check_frame("f3");
    check("min_start_gap", gap_min, 7);

    // Single-pixel build.
    fd0 = fdc_b;
    tick(1);
    fs_b = 1'b1;
    tick(1);
    fs_b = 1'b0;
    for (int k = 0; k < 50 && !fd_b; k++) tick(1);
    tick(3);
    check("one_count", q_b.size(), 1);
    if (q_b.size() > 0)
      check("one_pixel", q_b[0], {8'd3, 10'd0, 9'd0, 1'b1, 1'b1});
    check("one_done_pulses", fdc_b - fd0, 1);
    check("one_busy_end", busy_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
